mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single 64-bit memory bus between instruction fetch (I-side, read-only) and the
// memory unit (D-side, read/write). Sits between the pipeline's fetch/memunit and the external
// memory port. Grants one outstanding transaction at a time. D-side has priority; a starvation
// counter guarantees fetch forward progress.
// PARAMETERS
// AW            64  address width
// DW            64  data width
// STARVE_LIMIT  4   consecutive D grants while I waits before I is forced to win (1..15)
// PORTS
// clk            in   1   clock
// rst_n          in   1   async active-low reset
// i_addr         in   AW  fetch address; held stable while i_addr_valid=1
// i_addr_valid   in   1   fetch request; deassert = abandon (flush/redirect)
// i_data         out  DW  read data to fetch
// i_data_valid   out  1   1-cycle pulse: i_data valid, request complete
// d_addr         in   AW  memunit address; held stable while d_addr_valid=1
// d_addr_valid   in   1   memunit request; held until d_data_valid
// d_we           in   1   1=write, 0=read
// d_wdata        in   DW  write data
// d_be           in   DW/8  byte enables (writes only)
// d_data         out  DW  read data to memunit
// d_data_valid   out  1   1-cycle pulse: read data valid / write acknowledged
// mem_addr       out  AW  bus address
// mem_addr_valid out  1   bus request, held until mem_data_valid
// mem_we, mem_wdata, mem_be  out  1/DW/DW/8  bus write controls (0 when I owns bus)
// mem_data       in   DW  bus read data
// mem_data_valid in   1   bus completion pulse
// BEHAVIOUR
// - Reset: state IDLE, starve_cnt=0, all outputs 0 (valids, addr, we, wdata, be, data).
// - FSM IDLE / BUSY_I / BUSY_D / DRAIN_I. Grant decision is registered: request sampled in
//   IDLE at cycle n -> mem_addr_valid=1 with latched addr/we/wdata/be at n+1.
// - IDLE: if starve_cnt==STARVE_LIMIT && i_addr_valid -> BUSY_I; else d_addr_valid -> BUSY_D;
//   else i_addr_valid -> BUSY_I; else stay. Simultaneous requests: D wins unless starved.
// - starve_cnt: +1 on each D grant while i_addr_valid=1; cleared on I grant or when
//   i_addr_valid=0 in IDLE; saturates at STARVE_LIMIT.
// - BUSY_x: mem_* driven from latched request (not live inputs). On mem_data_valid:
//   x_data<=mem_data, x_data_valid pulses same cycle (combinational pass of valid, data
//   registered-through mux), mem_addr_valid drops, -> IDLE. Minimum turnaround 1 IDLE cycle.
// - Abandon: i_addr_valid falls in BUSY_I -> DRAIN_I; bus transaction still completes
//   (mem_addr_valid held), response discarded, i_data_valid stays 0, -> IDLE.
// - New i_addr_valid rising during DRAIN_I waits for IDLE; never matched to old response.
// - D-side never abandons; d_addr_valid drop in BUSY_D is a protocol error (assertion).
// - mem_data_valid in IDLE: ignored, no output pulse (assertion flags it).
// - Async reset mid-transaction: immediate return to IDLE, outputs 0; outstanding bus
//   response after reset ignored.
// STRUCTURE
// - State encodings and STARVE_LIMIT default in shared include raisin64_defines.vh
//   (`MPA_IDLE 2'd0, `MPA_BUSY_I 2'd1, `MPA_BUSY_D 2'd2, `MPA_DRAIN_I 2'd3).
// - One sub-module: mem_arb_starve (saturating starvation counter, inputs inc/clr, output
//   starved). Grant FSM, request latch and response demux stay in top.
// TESTING
// - I only, addr 0x100; mem_data_valid 3 cycles after mem_addr_valid with 0xDEAD ->
//   i_data=0xDEAD, one i_data_valid pulse, d_data_valid never set.
// - I and D raised same cycle -> D granted first (mem_we per d_we), I granted after D ack
//   plus 1 IDLE cycle.
// - D requests continuous with I waiting, STARVE_LIMIT=4 -> exactly 4 D grants then I
//   granted; counter back to 0.
// - D write 0x55AA at addr 0x2000, be=0x0F -> mem_we=1, mem_wdata=0x55AA, mem_be=0x0F;
//   ack yields d_data_valid pulse.
// - I granted, i_addr_valid dropped 1 cycle later, new I req 0x300 -> old response
//   discarded (no pulse), 0x300 issued after drain, its data delivered.
// - rst_n asserted while BUSY_D -> all outputs 0 same cycle; late mem_data_valid gives no pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: grant FSM encoding and the
// starvation counter width/saturation helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MPA_IDLE    = 2'd0,
    MPA_BUSY_I  = 2'd1,
    MPA_BUSY_D  = 2'd2,
    MPA_DRAIN_I = 2'd3
  } mpa_state_e;

  localparam int MPA_STARVE_LIMIT = 4;
  localparam int MPA_STARVE_W     = 4;

  typedef logic [MPA_STARVE_W-1:0] starve_cnt_t;

  function automatic starve_cnt_t starve_next(input starve_cnt_t cnt, input starve_cnt_t limit);
    return (cnt >= limit) ? limit : cnt + starve_cnt_t'(1);
  endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating count of D grants issued while fetch was waiting; starved_o
// forces the next grant to fetch.
module mem_arb_starve
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = MPA_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic starved_o
);

  localparam starve_cnt_t LIM = starve_cnt_t'(LIMIT);

  starve_cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = starve_next(cnt_q, LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign starved_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the memory bus between fetch (read-only)
// and the memory unit; D-side wins ties unless fetch has been starved.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = MPA_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_addr_i,
  input  logic            i_addr_valid_i,
  output logic [DW-1:0]   i_data_o,
  output logic            i_data_valid_o,
  input  logic [AW-1:0]   d_addr_i,
  input  logic            d_addr_valid_i,
  input  logic            d_we_i,
  input  logic [DW-1:0]   d_wdata_i,
  input  logic [DW/8-1:0] d_be_i,
  output logic [DW-1:0]   d_data_o,
  output logic            d_data_valid_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic            mem_addr_valid_o,
  output logic            mem_we_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  input  logic [DW-1:0]   mem_data_i,
  input  logic            mem_data_valid_i
);

  mpa_state_e      state_q;
  logic [AW-1:0]   mem_addr_q;
  logic            mem_addr_valid_q;
  logic            mem_we_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [DW/8-1:0] mem_be_q;
  logic [DW-1:0]   i_data_q;
  logic [DW-1:0]   d_data_q;
  logic            post_rst_q;

  logic gnt_i, gnt_d, starved, bus_done, i_hit, d_hit;
  logic starve_inc, starve_clr;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == MPA_IDLE) begin
      if (starved && i_addr_valid_i)
        gnt_i = 1'b1;
      else if (d_addr_valid_i)
        gnt_d = 1'b1;
      else if (i_addr_valid_i)
        gnt_i = 1'b1;
    end
  end

  assign starve_inc = gnt_d && i_addr_valid_i;
  assign starve_clr = gnt_i || ((state_q == MPA_IDLE) && !i_addr_valid_i);

  mem_arb_starve #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .starved_o(starved)
  );

  assign bus_done = (state_q != MPA_IDLE) && mem_data_valid_i;
  // Fetch only receives data if it still wants it in the completing cycle.
  assign i_hit    = (state_q == MPA_BUSY_I) && mem_data_valid_i && i_addr_valid_i;
  assign d_hit    = (state_q == MPA_BUSY_D) && mem_data_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= MPA_IDLE;
      mem_addr_q       <= '0;
      mem_addr_valid_q <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_wdata_q      <= '0;
      mem_be_q         <= '0;
      i_data_q         <= '0;
      d_data_q         <= '0;
      post_rst_q       <= 1'b1;
    end else begin
      case (state_q)
        MPA_IDLE: begin
          if (gnt_i) begin
            state_q          <= MPA_BUSY_I;
            mem_addr_valid_q <= 1'b1;
            mem_addr_q       <= i_addr_i;
            mem_we_q         <= 1'b0;
            mem_wdata_q      <= '0;
            mem_be_q         <= '0;
            post_rst_q       <= 1'b0;
          end else if (gnt_d) begin
            state_q          <= MPA_BUSY_D;
            mem_addr_valid_q <= 1'b1;
            mem_addr_q       <= d_addr_i;
            mem_we_q         <= d_we_i;
            mem_wdata_q      <= d_wdata_i;
            mem_be_q         <= d_be_i;
            post_rst_q       <= 1'b0;
          end
        end
        MPA_BUSY_I: begin
          if (mem_data_valid_i) begin
            state_q <= MPA_IDLE;
            if (i_addr_valid_i)
              i_data_q <= mem_data_i;
          end else if (!i_addr_valid_i) begin
            state_q <= MPA_DRAIN_I;
          end
        end
        MPA_BUSY_D: begin
          if (mem_data_valid_i) begin
            state_q  <= MPA_IDLE;
            d_data_q <= mem_data_i;
          end
        end
        MPA_DRAIN_I: begin
          if (mem_data_valid_i)
            state_q <= MPA_IDLE;
        end
        default: state_q <= MPA_IDLE;
      endcase
      if (bus_done) begin
        mem_addr_valid_q <= 1'b0;
        mem_addr_q       <= '0;
        mem_we_q         <= 1'b0;
        mem_wdata_q      <= '0;
        mem_be_q         <= '0;
      end
    end
  end

  assign mem_addr_o       = mem_addr_q;
  assign mem_addr_valid_o = mem_addr_valid_q;
  assign mem_we_o         = mem_we_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign mem_be_o         = mem_be_q;

  assign i_data_valid_o = i_hit;
  assign i_data_o       = i_hit ? mem_data_i : i_data_q;
  assign d_data_valid_o = d_hit;
  assign d_data_o       = d_hit ? mem_data_i : d_data_q;

  // A response arriving before the first post-reset grant belongs to a pre-reset transaction.
  a_d_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == MPA_BUSY_D) |-> d_addr_valid_i);
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_data_valid_i && (state_q == MPA_IDLE)) |-> post_rst_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] i_addr = '0;
  logic        i_addr_valid = 1'b0;
  logic [63:0] i_data;
  logic        i_data_valid;
  logic [63:0] d_addr = '0;
  logic        d_addr_valid = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_wdata = '0;
  logic [7:0]  d_be = '0;
  logic [63:0] d_data;
  logic        d_data_valid;
  logic [63:0] mem_addr;
  logic        mem_addr_valid;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic [63:0] mem_data = '0;
  logic        mem_data_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(64), .DW(64), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr_i(i_addr), .i_addr_valid_i(i_addr_valid),
    .i_data_o(i_data), .i_data_valid_o(i_data_valid),
    .d_addr_i(d_addr), .d_addr_valid_i(d_addr_valid), .d_we_i(d_we),
    .d_wdata_i(d_wdata), .d_be_i(d_be),
    .d_data_o(d_data), .d_data_valid_o(d_data_valid),
    .mem_addr_o(mem_addr), .mem_addr_valid_o(mem_addr_valid), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_data_i(mem_data), .mem_data_valid_i(mem_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] rdata;
    int          lat;
    bit          exp_we;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_be;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mav"},   64'(mem_addr_valid), 64'd0);
    chk({tag, "_maddr"}, mem_addr, 64'd0);
    chk({tag, "_mwe"},   64'(mem_we), 64'd0);
    chk({tag, "_mwd"},   mem_wdata, 64'd0);
    chk({tag, "_mbe"},   64'(mem_be), 64'd0);
    chk({tag, "_iv"},    64'(i_data_valid), 64'd0);
    chk({tag, "_dv"},    64'(d_data_valid), 64'd0);
    chk({tag, "_idata"}, i_data, 64'd0);
    chk({tag, "_ddata"}, d_data, 64'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    string t;
    t = $sformatf("vec%0d", k);
    d_we = v.we; d_wdata = v.wdata; d_be = v.be;
    if (v.is_d) begin
      d_addr = v.addr; d_addr_valid = 1'b1;
    end else begin
      i_addr = v.addr; i_addr_valid = 1'b1;
    end
    tick(); settle();
    chk({t, "_mav"},   64'(mem_addr_valid), 64'd1);
    chk({t, "_maddr"}, mem_addr, v.addr);
    chk({t, "_mwe"},   64'(mem_we), 64'(v.exp_we));
    chk({t, "_mwd"},   mem_wdata, v.exp_wdata);
    chk({t, "_mbe"},   64'(mem_be), 64'(v.exp_be));
    for (int w = 0; w < v.lat - 1; w++) begin
      tick(); settle();
      chk({t, "_wait_pulse"}, 64'({i_data_valid, d_data_valid}), 64'd0);
      chk({t, "_wait_mav"}, 64'(mem_addr_valid), 64'd1);
    end
    tick();
    mem_data = v.rdata; mem_data_valid = 1'b1;
    settle();
    chk({t, "_iv"}, 64'(i_data_valid), 64'(!v.is_d));
    chk({t, "_dv"}, 64'(d_data_valid), 64'(v.is_d));
    chk({t, "_data"}, v.is_d ? d_data : i_data, v.exp_data);
    tick();
    mem_data_valid = 1'b0; i_addr_valid = 1'b0; d_addr_valid = 1'b0;
    settle();
    chk({t, "_done_mav"}, 64'(mem_addr_valid), 64'd0);
    chk({t, "_done_pulse"}, 64'({i_data_valid, d_data_valid}), 64'd0);
    tick(); settle();
    chk({t, "_idle_mav"}, 64'(mem_addr_valid), 64'd0);
  endtask

  // reference model state (transaction level)
  bit          m_busy, m_own_d, m_i_kept, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  int          m_starve;
  bit          d_act, i_act, i_prev, d_prev, exp_i, exp_d, stop;
  int          resp_cnt, n_d, n_i;

  initial begin
    vt[0] = '{1'b0, 1'b0, 64'h100, 64'h0, 8'h00, 64'hDEAD, 3, 1'b0, 64'h0, 8'h00, 64'hDEAD};
    vt[1] = '{1'b1, 1'b1, 64'h2000, 64'h55AA, 8'h0F, 64'h77, 2, 1'b1, 64'h55AA, 8'h0F, 64'h77};
    vt[2] = '{1'b1, 1'b0, 64'h3008, 64'hFFFF, 8'hFF, 64'hCAFE_F00D, 1, 1'b0, 64'hFFFF, 8'hFF, 64'hCAFE_F00D};
    vt[3] = '{1'b0, 1'b1, 64'h8_0000_0040, 64'hFFFF_FFFF, 8'hAA, 64'h0123_4567_89AB_CDEF, 5,
              1'b0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF};

    // reset state
    #3;
    chk_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick(); settle();
    chk_all_zero("post_reset");

    for (int k = 0; k < 4; k++) apply_vec(vt[k], k);

    // simultaneous I and D: D first, I after one idle cycle
    i_addr = 64'h600; i_addr_valid = 1'b1;
    d_addr = 64'h700; d_we = 1'b1; d_wdata = 64'hAB; d_be = 8'h03; d_addr_valid = 1'b1;
    tick(); settle();
    chk("sim_first_addr", mem_addr, 64'h700);
    chk("sim_first_we", 64'(mem_we), 64'd1);
    tick(); mem_data = 64'h11; mem_data_valid = 1'b1; settle();
    chk("sim_d_pulse", 64'(d_data_valid), 64'd1);
    chk("sim_i_quiet", 64'(i_data_valid), 64'd0);
    tick(); mem_data_valid = 1'b0; d_addr_valid = 1'b0; settle();
    chk("sim_gap_mav", 64'(mem_addr_valid), 64'd0);
    tick(); settle();
    chk("sim_i_mav", 64'(mem_addr_valid), 64'd1);
    chk("sim_i_addr", mem_addr, 64'h600);
    chk("sim_i_we", 64'(mem_we), 64'd0);
    tick(); mem_data = 64'h66; mem_data_valid = 1'b1; settle();
    chk("sim_i_pulse", 64'(i_data_valid), 64'd1);
    chk("sim_i_data", i_data, 64'h66);
    tick(); mem_data_valid = 1'b0; i_addr_valid = 1'b0;
    tick(); tick();

    // starvation: continuous D with I waiting
    i_addr = 64'h4000; i_addr_valid = 1'b1;
    d_addr = 64'h5000; d_we = 1'b0; d_addr_valid = 1'b1;
    n_d = 0; n_i = 0;
    for (int c = 0; c < 80 && n_i < 2; c++) begin
      tick();
      if (mem_data_valid) mem_data_valid = 1'b0;
      else if (mem_addr_valid) begin
        if (mem_addr == 64'h5000) begin
          n_d++; mem_data = 64'(c); mem_data_valid = 1'b1;
        end else begin
          n_i++;
          chk("starve_d_grants", 64'(n_d), 64'(LIM));
          n_d = 0;
          if (n_i < 2) mem_data_valid = 1'b1;
        end
      end
    end
    chk("starve_i_grants", 64'(n_i), 64'd2);
    mem_data = 64'h44; mem_data_valid = 1'b1; settle();
    chk("starve_i_pulse", 64'(i_data_valid), 64'd1);
    tick(); mem_data_valid = 1'b0; i_addr_valid = 1'b0; d_addr_valid = 1'b0;
    tick(); tick();

    // abandon: old response discarded, new request issued after drain
    i_addr = 64'h100; i_addr_valid = 1'b1;
    tick(); settle();
    chk("abn_grant_addr", mem_addr, 64'h100);
    tick(); i_addr_valid = 1'b0;
    tick(); i_addr = 64'h300; i_addr_valid = 1'b1; settle();
    chk("abn_drain_mav", 64'(mem_addr_valid), 64'd1);
    tick(); mem_data = 64'hBAD; mem_data_valid = 1'b1; settle();
    chk("abn_old_no_pulse", 64'(i_data_valid), 64'd0);
    tick(); mem_data_valid = 1'b0; settle();
    chk("abn_idle_mav", 64'(mem_addr_valid), 64'd0);
    tick(); settle();
    chk("abn_new_mav", 64'(mem_addr_valid), 64'd1);
    chk("abn_new_addr", mem_addr, 64'h300);
    tick(); mem_data = 64'h3333; mem_data_valid = 1'b1; settle();
    chk("abn_new_pulse", 64'(i_data_valid), 64'd1);
    chk("abn_new_data", i_data, 64'h3333);
    tick(); mem_data_valid = 1'b0; i_addr_valid = 1'b0;
    tick();

    // randomized run against the reference model
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_busy = 0; m_own_d = 0; m_i_kept = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    m_starve = 0; d_act = 0; i_act = 0; i_prev = 0; d_prev = 0; resp_cnt = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      stop = (c >= 2960);
      if (d_act && d_prev) begin
        d_addr_valid = 1'b0; d_act = 1'b0;
      end else if (!d_act && !stop && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1; d_addr_valid = 1'b1; d_addr = {$urandom, $urandom};
        d_we = 1'($urandom_range(0, 1)); d_wdata = {$urandom, $urandom}; d_be = 8'($urandom);
      end
      if (i_act && (i_prev || stop || $urandom_range(0, 9) == 0)) begin
        i_addr_valid = 1'b0; i_act = 1'b0;
      end else if (!i_act && !stop && $urandom_range(0, 1) == 0) begin
        i_act = 1'b1; i_addr_valid = 1'b1; i_addr = {$urandom, $urandom};
      end
      mem_data_valid = 1'b0;
      if (mem_addr_valid) begin
        if (resp_cnt < 0) resp_cnt = int'($urandom_range(0, 3));
        if (resp_cnt == 0) begin
          mem_data_valid = 1'b1; mem_data = {$urandom, $urandom}; resp_cnt = -1;
        end else resp_cnt--;
      end
      settle();
      chk("rnd_mav", 64'(mem_addr_valid), 64'(m_busy));
      if (m_busy) begin
        chk("rnd_addr", mem_addr, m_addr);
        chk("rnd_we", 64'(mem_we), 64'(m_we));
        chk("rnd_wdata", mem_wdata, m_wdata);
        chk("rnd_be", 64'(mem_be), 64'(m_be));
      end
      exp_i = m_busy && !m_own_d && m_i_kept && i_addr_valid && mem_data_valid;
      exp_d = m_busy && m_own_d && mem_data_valid;
      chk("rnd_ipulse", 64'(i_data_valid), 64'(exp_i));
      chk("rnd_dpulse", 64'(d_data_valid), 64'(exp_d));
      if (exp_i) chk("rnd_idata", i_data, mem_data);
      if (exp_d) chk("rnd_ddata", d_data, mem_data);
      i_prev = i_data_valid; d_prev = d_data_valid;
      if (m_busy) begin
        if (mem_data_valid) m_busy = 0;
        else if (!i_addr_valid) m_i_kept = 0;
      end else if (i_addr_valid && (m_starve >= LIM || !d_addr_valid)) begin
        m_busy = 1; m_own_d = 0; m_i_kept = 1; m_addr = i_addr;
        m_we = 0; m_wdata = '0; m_be = '0; m_starve = 0;
      end else if (d_addr_valid) begin
        m_busy = 1; m_own_d = 1; m_addr = d_addr;
        m_we = d_we; m_wdata = d_wdata; m_be = d_be;
        m_starve = i_addr_valid ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
      end else begin
        m_starve = 0;
      end
    end
    i_addr_valid = 1'b0; d_addr_valid = 1'b0; mem_data_valid = 1'b0;
    tick(); tick();

    // async reset during a D transaction; late response ignored
    d_addr = 64'h9000; d_we = 1'b1; d_wdata = 64'h5A5A; d_be = 8'hF0; d_addr_valid = 1'b1;
    tick(); settle();
    chk("rst_busy_mav", 64'(mem_addr_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    d_addr_valid = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); mem_data = 64'hBEEF; mem_data_valid = 1'b1; settle();
    chk("rst_late_dv", 64'(d_data_valid), 64'd0);
    chk("rst_late_iv", 64'(i_data_valid), 64'd0);
    chk("rst_late_mav", 64'(mem_addr_valid), 64'd0);
    tick(); mem_data_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
